// File: rtl/branch_pred_pkg.sv
// Predictor-local types.
package branch_pred_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } bp_state_t;

endpackage

// File: rtl/torv32_pkg.sv
// Shared RV32 decode helpers: opcode constants, branch/jump immediates, link-register test.
package torv32_pkg;

    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/branch_pred_if.sv
// Predict/update/performance bus between the pipeline (master) and the branch predictor (slave).
interface branch_pred_if #(
    parameter int BHT_BITS = 10,
    parameter int GHR_BITS = 8
);
    logic                ready;
    logic                p_valid;
    logic                p_stall;
    logic [31:0]         p_pc;
    logic [31:0]         p_instr;
    logic                p_take;
    logic [31:0]         p_target;
    logic [BHT_BITS-1:0] p_index;
    logic [GHR_BITS-1:0] p_ghr;
    logic                u_valid;
    logic [BHT_BITS-1:0] u_index;
    logic [GHR_BITS-1:0] u_ghr;
    logic                u_taken;
    logic                u_mispredict;
    logic [31:0]         n_pred;
    logic [31:0]         n_mispred;

    modport master (
        output p_valid, p_stall, p_pc, p_instr,
        output u_valid, u_index, u_ghr, u_taken, u_mispredict,
        input  ready, p_take, p_target, p_index, p_ghr, n_pred, n_mispred
    );

    modport slave (
        input  p_valid, p_stall, p_pc, p_instr,
        input  u_valid, u_index, u_ghr, u_taken, u_mispredict,
        output ready, p_take, p_target, p_index, p_ghr, n_pred, n_mispred
    );
endinterface

// File: rtl/branch_pred_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module bp_ras #(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_addr,
    output logic [31:0] top,
    output logic        empty
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [31:0]   mem [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_ptr;
    logic [PW:0]   count;
    logic          swap;

    assign top_ptr = ptr - 1'b1;
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    // push+pop on a non-empty stack replaces the top in place
    assign swap    = push && pop && !empty;

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[swap ? top_ptr : ptr] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (swap) begin
            ptr   <= ptr;
        end else if (pop && !empty) begin
            ptr   <= top_ptr;
            count <= count - 1'b1;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (count != (PW+1)'(RAS_DEPTH)) begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/branch_pred.sv
// Gshare direction predictor with 2-bit counters, global history and a return-address stack.
module branch_pred
    import torv32_pkg::*;
    import branch_pred_pkg::*;
#(
    parameter int BHT_BITS  = 10,
    parameter int GHR_BITS  = 8,
    parameter int RAS_DEPTH = 4
) (
    input logic         clk,
    input logic         reset,
    branch_pred_if.slave bp
);
    logic [1:0]          bht [2**BHT_BITS];
    bp_state_t           state;
    logic [BHT_BITS-1:0] init_idx;
    logic [GHR_BITS-1:0] ghr;
    logic                ready_q;
    logic [31:0]         n_pred_q;
    logic [31:0]         n_mispred_q;

    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic                is_br, is_jal, is_jalr, is_ret;
    logic [BHT_BITS-1:0] idx;
    logic                accepted;
    logic                take;
    logic [31:0]         target;
    logic [31:0]         link_addr;
    logic                ras_push, ras_pop, ras_empty;
    logic [31:0]         ras_top;
    logic                bht_we;
    logic [BHT_BITS-1:0] bht_wa;
    logic [1:0]          bht_wd;
    logic [1:0]          upd_cur;

    assign opcode    = bp.p_instr[6:0];
    assign rd        = bp.p_instr[11:7];
    assign rs1       = bp.p_instr[19:15];
    assign is_br     = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_ret    = is_jalr && (rd == 5'd0) && is_link(rs1);
    assign idx       = bp.p_pc[BHT_BITS+1:2] ^ BHT_BITS'(ghr);
    assign accepted  = bp.p_valid && !bp.p_stall && ready_q;
    assign link_addr = bp.p_pc + 32'd4;
    assign ras_push  = accepted && (is_jal || is_jalr) && is_link(rd);
    assign ras_pop   = accepted && is_jalr && is_link(rs1) && ((rd == 5'd0) || is_link(rd));

    bp_ras #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_addr(link_addr),
        .top      (ras_top),
        .empty    (ras_empty)
    );

    always_comb begin
        take   = 1'b0;
        target = link_addr;
        if (is_br) begin
            take   = ready_q && bht[idx][1];
            target = bp.p_pc + imm_b(bp.p_instr);
        end else if (is_jal) begin
            take   = ready_q;
            target = bp.p_pc + imm_j(bp.p_instr);
        end else if (is_ret && !ras_empty) begin
            take   = ready_q;
            target = ras_top;
        end
    end

    // Single write port shared by the init sweep and resolved-branch updates.
    always_comb begin
        upd_cur = bht[bp.u_index];
        bht_we  = 1'b0;
        bht_wa  = bp.u_index;
        bht_wd  = upd_cur;
        if (state == ST_INIT) begin
            bht_we = 1'b1;
            bht_wa = init_idx;
            bht_wd = 2'b01;
        end else if (bp.u_valid) begin
            bht_we = 1'b1;
            if (bp.u_taken) begin
                bht_wd = (upd_cur == 2'b11) ? upd_cur : upd_cur + 2'b01;
            end else begin
                bht_wd = (upd_cur == 2'b00) ? upd_cur : upd_cur - 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bht_we) begin
            bht[bht_wa] <= bht_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            init_idx    <= '0;
            ready_q     <= 1'b0;
            ghr         <= '0;
            n_pred_q    <= '0;
            n_mispred_q <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == '1) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accepted && is_br) begin
                        ghr      <= GHR_BITS'({ghr, take});
                        n_pred_q <= n_pred_q + 32'd1;
                    end
                    // resolved mispredict wins over the speculative shift above
                    if (bp.u_valid && bp.u_mispredict) begin
                        ghr         <= GHR_BITS'({bp.u_ghr, bp.u_taken});
                        n_mispred_q <= n_mispred_q + 32'd1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bp.ready     = ready_q;
    assign bp.p_take    = take;
    assign bp.p_target  = target;
    assign bp.p_index   = idx;
    assign bp.p_ghr     = ghr;
    assign bp.n_pred    = n_pred_q;
    assign bp.n_mispred = n_mispred_q;
endmodule

// File: tb/tb_branch_pred.sv
// Randomized and directed checks of branch_pred against a queue/array reference model.
module tb_branch_pred;
    localparam int BB = 4;
    localparam int GB = 4;
    localparam int NE = 16;

    logic clk;
    logic reset;

    branch_pred_if #(.BHT_BITS(BB), .GHR_BITS(GB)) bus ();

    branch_pred #(.BHT_BITS(BB), .GHR_BITS(GB), .RAS_DEPTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bp   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // reference model state
    int          m_bht [NE];
    int unsigned m_ghr;
    int          m_init;
    int unsigned m_ras [$];
    int unsigned m_npred, m_nmis;
    bit          m_known = 0;
    int          m_take;
    int unsigned m_target, m_idx;

    // what the current stimulus instruction means (0 B, 1 JAL, 2 JALR, 3 other)
    int          cur_kind, cur_imm, cur_rd, cur_rs1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_lnk(input int r);
        return (r == 1) || (r == 5);
    endfunction

    task automatic set_b(input int imm);
        logic [31:0] v;
        v = imm;
        cur_kind = 0; cur_imm = imm;
        bus.p_instr = {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], 7'h63};
    endtask

    task automatic set_jal(input int imm, input int rd);
        logic [31:0] v;
        logic [4:0]  r;
        v = imm; r = 5'(rd);
        cur_kind = 1; cur_imm = imm; cur_rd = rd;
        bus.p_instr = {v[20], v[10:1], v[11], v[19:12], r, 7'h6F};
    endtask

    task automatic set_jalr(input int rd, input int rs1);
        logic [11:0] off;
        off = 12'($urandom);
        cur_kind = 2; cur_rd = rd; cur_rs1 = rs1;
        bus.p_instr = {off, 5'(rs1), 3'b000, 5'(rd), 7'h67};
    endtask

    task automatic set_other();
        logic [6:0] ops [5];
        ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h37};
        cur_kind = 3;
        bus.p_instr = {25'($urandom), ops[$urandom_range(0, 4)]};
    endtask

    task automatic idle();
        bus.p_valid = 0; bus.p_stall = 0; bus.p_pc = '0;
        bus.u_valid = 0; bus.u_index = '0; bus.u_ghr = '0; bus.u_taken = 0; bus.u_mispredict = 0;
        cur_kind = 3; bus.p_instr = 32'h0000_0013;
    endtask

    // Evaluate the model's prediction mid-cycle and compare every output.
    task automatic settle();
        bit rdy;
        @(negedge clk);
        rdy      = (m_init == NE);
        m_idx    = ((bus.p_pc >> 2) & (NE - 1)) ^ m_ghr;
        m_take   = 0;
        m_target = bus.p_pc + 4;
        case (cur_kind)
            0: begin m_take = rdy && (m_bht[m_idx] >= 2); m_target = bus.p_pc + 32'(cur_imm); end
            1: begin m_take = rdy; m_target = bus.p_pc + 32'(cur_imm); end
            2: if (cur_rd == 0 && is_lnk(cur_rs1) && m_ras.size() > 0) begin
                   m_take = rdy; m_target = m_ras[$];
               end
            default: ;
        endcase
        if (m_known) begin
            check_eq("ready", bus.ready, rdy);
            check_eq("p_take", bus.p_take, m_take);
            check_eq("p_target", bus.p_target, m_target);
            check_eq("p_index", bus.p_index, m_idx);
            check_eq("p_ghr", bus.p_ghr, m_ghr);
            check_eq("n_pred", bus.n_pred, m_npred);
            check_eq("n_mispred", bus.n_mispred, m_nmis);
        end
    endtask

    // Advance the model with the inputs present at the clock edge.
    task automatic tick();
        bit acc, push, pop;
        @(posedge clk);
        if (reset) begin
            m_known = 1; m_init = 0; m_ghr = 0; m_ras.delete(); m_npred = 0; m_nmis = 0;
        end else if (m_init < NE) begin
            m_init++;
            if (m_init == NE) foreach (m_bht[i]) m_bht[i] = 1;
        end else begin
            acc = bus.p_valid && !bus.p_stall;
            if (acc && cur_kind == 0) begin
                m_npred++;
                m_ghr = ((m_ghr << 1) | m_take) & (2**GB - 1);
            end
            if (bus.u_valid && bus.u_mispredict) begin
                m_nmis++;
                m_ghr = ((int'(bus.u_ghr) << 1) | bus.u_taken) & (2**GB - 1);
            end
            if (bus.u_valid) begin
                if (bus.u_taken) m_bht[bus.u_index] = (m_bht[bus.u_index] == 3) ? 3 : m_bht[bus.u_index] + 1;
                else             m_bht[bus.u_index] = (m_bht[bus.u_index] == 0) ? 0 : m_bht[bus.u_index] - 1;
            end
            push = acc && (cur_kind == 1 || cur_kind == 2) && is_lnk(cur_rd);
            pop  = acc && cur_kind == 2 && is_lnk(cur_rs1) && (cur_rd == 0 || is_lnk(cur_rd));
            if (push && pop && m_ras.size() > 0) begin
                m_ras[m_ras.size() - 1] = bus.p_pc + 4;
            end else if (pop && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end else if (push) begin
                m_ras.push_back(bus.p_pc + 4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        int unsigned ret_exp [4];
        int r;
        ret_exp = '{32'h54, 32'h44, 32'h34, 32'h24};
        idle();
        reset = 1;
        step(); step();
        reset = 0;

        // table initialisation: ready after exactly 16 cycles, no B-type taken before
        bus.p_valid = 1; bus.p_pc = 32'h100; set_b(64);
        for (int i = 0; i < NE; i++) begin
            settle();
            check_eq("init_ready", bus.ready, 0);
            check_eq("init_take", bus.p_take, 0);
            tick();
        end
        bus.p_valid = 0;
        settle();
        check_eq("ready_rise", bus.ready, 1);
        tick();

        // counter training at index 0 with ghr held at 0
        bus.u_valid = 1; bus.u_index = 0; bus.u_taken = 1;
        step(); step();
        bus.u_valid = 0;
        settle();
        check_eq("trained_take", bus.p_take, 1);
        check_eq("trained_target", bus.p_target, 32'h140);
        tick();

        // saturation at 11 and at 00
        bus.u_valid = 1; bus.u_taken = 1;
        repeat (3) step();
        bus.u_taken = 0;
        repeat (5) step();
        bus.u_taken = 1;
        step();
        bus.u_valid = 0;
        settle();
        check_eq("sat_low_take", bus.p_take, 0);
        tick();

        // RAS overflow and drain
        bus.p_valid = 1;
        for (int k = 1; k <= 5; k++) begin
            bus.p_pc = 32'(k * 16); set_jal(256, 1);
            step();
        end
        bus.p_pc = 32'h200; set_jalr(0, 1);
        for (int k = 0; k < 4; k++) begin
            settle();
            check_eq("ret_take", bus.p_take, 1);
            check_eq("ret_target", bus.p_target, ret_exp[k]);
            tick();
        end
        settle();
        check_eq("ret_empty_take", bus.p_take, 0);
        tick();

        // stalled JAL predicts but changes nothing
        bus.p_stall = 1; bus.p_pc = 32'h300; set_jal(8, 1);
        settle();
        check_eq("stall_take", bus.p_take, 1);
        tick();
        bus.p_stall = 0; bus.p_pc = 32'h400; set_jalr(0, 5);
        settle();
        check_eq("stall_ras_empty", bus.p_take, 0);
        check_eq("stall_ghr", bus.p_ghr, 0);
        tick();

        // mispredict restore overrides a same-cycle speculative shift
        bus.p_valid = 0;
        bus.u_valid = 1; bus.u_index = 5; bus.u_taken = 1; bus.u_mispredict = 0;
        step(); step();
        bus.u_mispredict = 1; bus.u_ghr = 4'h2;
        step();
        bus.p_valid = 1; bus.p_pc = 32'h100; set_b(-8);
        bus.u_index = 9; bus.u_ghr = 4'h3; bus.u_taken = 0;
        settle();
        check_eq("spec_ghr", bus.p_ghr, 5);
        check_eq("spec_take", bus.p_take, 1);
        tick();
        idle();
        settle();
        check_eq("restore_ghr", bus.p_ghr, 6);
        check_eq("restore_nmis", bus.n_mispred, 2);
        tick();

        // randomized traffic, with occasional mid-run resets
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            bus.p_valid = ($urandom_range(0, 3) != 0);
            bus.p_stall = ($urandom_range(0, 4) == 0);
            bus.p_pc = $urandom_range(0, 1023) << 2;
            r = $urandom_range(0, 9);
            if (r <= 4)      set_b(int'($urandom_range(0, 4095)) * 2 - 4096);
            else if (r == 5) set_jal(int'($urandom_range(0, 1048575)) * 2 - 1048576, (r == 5 && $urandom_range(0, 1) == 1) ? 1 : ($urandom_range(0, 1) == 1 ? 5 : $urandom_range(0, 3) * 2));
            else if (r <= 7) set_jalr($urandom_range(0, 1) == 1 ? 0 : ($urandom_range(0, 1) == 1 ? 1 : ($urandom_range(0, 1) == 1 ? 5 : 2)),
                                      $urandom_range(0, 2) == 0 ? 2 : ($urandom_range(0, 1) == 1 ? 1 : 5));
            else             set_other();
            bus.u_valid = $urandom_range(0, 1);
            bus.u_index = BB'($urandom);
            bus.u_ghr = GB'($urandom);
            bus.u_taken = $urandom_range(0, 1);
            bus.u_mispredict = ($urandom_range(0, 3) == 0);
            step();
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
